// File: rtl/aip_slave_interface_pkg.sv
// Shared definitions for the AIP slave port: config codes, control/status bit
// positions and the core sequencing states.
package aip_pkg;

  localparam logic [4:0] CFG_MEMIN  = 5'h00;
  localparam logic [4:0] CFG_MEMOUT = 5'h01;
  localparam logic [4:0] CFG_PTRIN  = 5'h02;
  localparam logic [4:0] CFG_PTROUT = 5'h03;
  localparam logic [4:0] CFG_PARAM  = 5'h04;
  localparam logic [4:0] CFG_CTRL   = 5'h1D;
  localparam logic [4:0] CFG_STATUS = 5'h1E;
  localparam logic [4:0] CFG_IPID   = 5'h1F;

  localparam int unsigned CTRL_INT_EN   = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_INTEN = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [2:0] status_bits(input logic int_en, input logic done,
                                             input logic busy);
    logic [2:0] s;
    s             = '0;
    s[STAT_INTEN] = int_en;
    s[STAT_DONE]  = done;
    s[STAT_BUSY]  = busy;
    return s;
  endfunction

endpackage

// File: rtl/aip_slave_interface_if.sv
// Master-to-slave AIP port bundle: config/strobes/data from the SoC controller,
// read data and interrupt back to it.
interface aip_slave_interface_if #(
  parameter int DATA_WORD = 32
);
  logic [4:0]           configAIP;
  logic                 readAIP;
  logic                 writeAIP;
  logic [DATA_WORD-1:0] dataInAIP;
  logic                 startAIP;
  logic [DATA_WORD-1:0] dataOutAIP;
  logic                 intAIP;

  modport master (
    output configAIP, readAIP, writeAIP, dataInAIP, startAIP,
    input  dataOutAIP, intAIP
  );

  modport slave (
    input  configAIP, readAIP, writeAIP, dataInAIP, startAIP,
    output dataOutAIP, intAIP
  );
endinterface

// File: rtl/aip_slave_dpram.sv
// Simple dual-port buffer: one write port, one registered read port with enable.
// A same-cycle read and write to one address returns the old word.
module aip_slave_dpram #(
  parameter  int DATA_WORD = 32,
  parameter  int DEPTH     = 64,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [DATA_WORD-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [DATA_WORD-1:0] o_rd_data
);

  logic [DATA_WORD-1:0] r_mem [DEPTH];
  logic [DATA_WORD-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aip_slave_interface.sv
// IP-core end of an AIP port: decodes master config/read/write/start, hosts the
// input/output buffers and param/status registers, sequences the core, raises int.
module aip_slave_interface
  import aip_pkg::*;
#(
  parameter  int                   DATA_WORD = 32,
  parameter  int                   DEPTH     = 64,
  parameter  logic [DATA_WORD-1:0] IP_ID     = '0,
  localparam int                   ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_a,
  aip_slave_interface_if.slave aip,
  output logic                 o_core_start,
  output logic [DATA_WORD-1:0] o_core_param,
  input  logic [ADDR_W-1:0]    i_core_rd_addr,
  output logic [DATA_WORD-1:0] o_core_rd_data,
  input  logic                 i_core_we,
  input  logic [ADDR_W-1:0]    i_core_wr_addr,
  input  logic [DATA_WORD-1:0] i_core_wr_data,
  input  logic                 i_core_done
);

  state_t               r_state, w_state_nxt;
  logic                 r_start_d, r_core_start, r_done, r_int_en, r_int, r_sel_mem;
  logic [ADDR_W-1:0]    r_ptr_in, r_ptr_out;
  logic [DATA_WORD-1:0] r_param, r_dout, w_outbuf_rd;
  logic                 w_busy, w_start_edge, w_launch, w_core_fin;
  logic                 w_wr, w_rd, w_memin_we, w_memout_rd;
  logic [4:0]           w_cfg;

  assign w_cfg        = aip.configAIP;
  assign w_wr         = aip.writeAIP;
  assign w_rd         = aip.readAIP & ~aip.writeAIP;
  assign w_busy       = (r_state == ST_RUN);
  assign w_start_edge = aip.startAIP & ~r_start_d;
  assign w_core_fin   = w_busy & i_core_done;
  assign w_memin_we   = w_wr & (w_cfg == CFG_MEMIN) & ~w_busy;
  assign w_memout_rd  = w_rd & (w_cfg == CFG_MEMOUT);

  always_ff @(posedge i_clk) begin
    if (!i_rst_a) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = ST_RUN;
          w_launch    = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_core_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_a) begin
      r_start_d    <= 1'b0;
      r_core_start <= 1'b0;
      r_done       <= 1'b0;
      r_int_en     <= 1'b0;
      r_int        <= 1'b0;
      r_sel_mem    <= 1'b0;
      r_ptr_in     <= '0;
      r_ptr_out    <= '0;
      r_param      <= '0;
      r_dout       <= '0;
    end else begin
      r_start_d    <= aip.startAIP;
      r_core_start <= w_launch;
      r_int        <= r_done & r_int_en;

      if (w_wr) begin
        case (w_cfg)
          CFG_MEMIN:  if (!w_busy) r_ptr_in <= r_ptr_in + ADDR_W'(1);
          CFG_PTRIN:  if (!w_busy) r_ptr_in <= aip.dataInAIP[ADDR_W-1:0];
          CFG_PTROUT: r_ptr_out <= aip.dataInAIP[ADDR_W-1:0];
          CFG_PARAM:  if (!w_busy) r_param <= aip.dataInAIP;
          CFG_CTRL:   r_int_en <= aip.dataInAIP[CTRL_INT_EN];
          default: ;
        endcase
      end

      // completion beats a same-cycle clr_done; a new launch clears stale done
      if (w_core_fin) begin
        r_done <= 1'b1;
      end else if (w_launch) begin
        r_done <= 1'b0;
      end else if (w_wr && (w_cfg == CFG_CTRL) && aip.dataInAIP[CTRL_CLR_DONE]) begin
        r_done <= 1'b0;
      end

      // MEMOUT data comes straight from the buffer's read register, which only
      // updates on a MEMOUT read, so both paths hold until the next read
      if (w_rd) begin
        r_sel_mem <= (w_cfg == CFG_MEMOUT);
        if (w_memout_rd) begin
          r_ptr_out <= r_ptr_out + ADDR_W'(1);
        end
        case (w_cfg)
          CFG_PARAM:  r_dout <= r_param;
          CFG_STATUS: r_dout <= DATA_WORD'(status_bits(r_int_en, r_done, w_busy));
          CFG_IPID:   r_dout <= IP_ID;
          default:    r_dout <= '0;
        endcase
      end
    end
  end

  aip_slave_dpram #(
    .DATA_WORD(DATA_WORD),
    .DEPTH    (DEPTH)
  ) u_inbuf (
    .i_clk    (i_clk),
    .i_we     (w_memin_we),
    .i_wr_addr(r_ptr_in),
    .i_wr_data(aip.dataInAIP),
    .i_rd_en  (1'b1),
    .i_rd_addr(i_core_rd_addr),
    .o_rd_data(o_core_rd_data)
  );

  aip_slave_dpram #(
    .DATA_WORD(DATA_WORD),
    .DEPTH    (DEPTH)
  ) u_outbuf (
    .i_clk    (i_clk),
    .i_we     (i_core_we),
    .i_wr_addr(i_core_wr_addr),
    .i_wr_data(i_core_wr_data),
    .i_rd_en  (w_memout_rd),
    .i_rd_addr(r_ptr_out),
    .o_rd_data(w_outbuf_rd)
  );

  assign aip.dataOutAIP = r_sel_mem ? w_outbuf_rd : r_dout;
  assign aip.intAIP     = r_int;
  assign o_core_start   = r_core_start;
  assign o_core_param   = r_param;

endmodule
